// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared types, funct3 codes and selector mapping for the store RMW controller
package store_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_MERGE = 3'd2,
        ST_WR    = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SEL_SD = 2'b00,
        SEL_SW = 2'b01,
        SEL_SH = 2'b10,
        SEL_SB = 2'b11
    } store_sel_t;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    function automatic store_sel_t funct3_to_sel(input logic [2:0] f3);
        case (f3)
            F3_SB:   return SEL_SB;
            F3_SH:   return SEL_SH;
            F3_SW:   return SEL_SW;
            default: return SEL_SD;
        endcase
    endfunction

endpackage

// File: rtl/store_merge_mux.sv
// rtl/store_merge_mux.sv - replaces the low bytes of a memory doubleword with new store data
module store_merge_mux
    import store_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  store_sel_t        sel,
    input  logic [DATA_W-1:0] new_data,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] merged
);

    logic [DATA_W-1:0] mask;

    always_comb begin
        case (sel)
            SEL_SB:  mask = DATA_W'(64'h0000_0000_0000_00FF);
            SEL_SH:  mask = DATA_W'(64'h0000_0000_0000_FFFF);
            SEL_SW:  mask = DATA_W'(64'h0000_0000_FFFF_FFFF);
            default: mask = '1;
        endcase
        merged = (mem_data & ~mask) | (new_data & mask);
    end

endmodule

// File: rtl/store_rmw_controller.sv
// rtl/store_rmw_controller.sv - sequences sb/sh/sw/sd as read-modify-write on a 64-bit data memory
module store_rmw_controller
    import store_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 64,
    parameter int TIMEOUT      = 255,
    parameter int SKIP_READ_SD = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(7);
    localparam logic [7:0]        TO_LAST    = 8'(TIMEOUT - 1);

    state_t            state, next_state;
    store_sel_t        sel_q;
    logic [DATA_W-1:0] data_q, rdata_q, merged;
    logic [7:0]        cnt;
    logic              accept, timed_out;
    logic              busy_d, done_d, error_d, req_d, we_d;

    assign accept    = (state == ST_IDLE) && start;
    assign timed_out = (cnt == TO_LAST);

    store_merge_mux #(.DATA_W(DATA_W)) u_merge (
        .sel      (sel_q),
        .new_data (data_q),
        .mem_data (rdata_q),
        .merged   (merged)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (funct3[2])                                 next_state = ST_ERR;
                    else if (funct3 == F3_SD && SKIP_READ_SD != 0) next_state = ST_WR;
                    else                                           next_state = ST_RD;
                end
            end
            ST_RD: begin
                if (mem_ack)        next_state = ST_MERGE;
                else if (timed_out) next_state = ST_ERR;
            end
            ST_MERGE: next_state = ST_WR;
            ST_WR: begin
                if (mem_ack)        next_state = ST_DONE;
                else if (timed_out) next_state = ST_ERR;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next_state and registered, so they line up with the state they belong to.
    always_comb begin
        busy_d  = (next_state != ST_IDLE);
        done_d  = (next_state == ST_DONE);
        error_d = (next_state == ST_ERR);
        req_d   = (next_state == ST_RD) || (next_state == ST_WR);
        we_d    = (next_state == ST_WR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            data_q    <= '0;
            rdata_q   <= '0;
            sel_q     <= SEL_SD;
            cnt       <= '0;
        end else begin
            busy    <= busy_d;
            done    <= done_d;
            error   <= error_d;
            mem_req <= req_d;
            mem_we  <= we_d;
            if (accept) begin
                mem_addr <= addr & ALIGN_MASK;
                data_q   <= store_data;
                sel_q    <= funct3_to_sel(funct3);
            end
            if (state == ST_RD && mem_ack) rdata_q <= mem_rdata;
            if (state == ST_MERGE)                     mem_wdata <= merged;
            else if (accept && next_state == ST_WR)    mem_wdata <= store_data;
            if (next_state != state)                   cnt <= '0;
            else if (state == ST_RD || state == ST_WR) cnt <= cnt + 8'd1;
        end
    end

endmodule
